// File: rtl/regbank85_pkg.sv
// regbank85_pkg: shared codes for the 8085 register bank.
//   Byte select codes, register-pair codes, load-sequencer state encoding
//   and the field widths used by the interface and the RTL.
package regbank85_pkg;

  localparam int unsigned DATASIZE_DEF = 8;
  localparam int unsigned SEL_W        = 3;
  localparam int unsigned PAIR_W       = 2;
  localparam int unsigned NUM_BYTES    = 8;

  typedef enum logic [SEL_W-1:0] {
    REG_B    = 3'b000,
    REG_C    = 3'b001,
    REG_D    = 3'b010,
    REG_E    = 3'b011,
    REG_H    = 3'b100,
    REG_L    = 3'b101,
    REG_NONE = 3'b110,
    REG_A    = 3'b111
  } reg_sel_e;

  typedef enum logic [PAIR_W-1:0] {
    PAIR_BC = 2'b00,
    PAIR_DE = 2'b01,
    PAIR_HL = 2'b10,
    PAIR_SP = 2'b11
  } pair_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD_LO = 2'd1,
    ST_LOAD_HI = 2'd2
  } state_e;

endpackage

// File: rtl/regbank85_if.sv
// regbank85_if: byte/pair access bus of the register bank.
//   enb, sel, data_in       byte write strobe, byte select, write/load data
//   data_out                byte read at sel (combinational)
//   psel, pinc, pdec, pload pair select, increment, decrement, two-byte load start
//   pdata_out               pair read at psel (combinational)
//   busy, done              load sequence in progress / completion pulse
interface regbank85_if #(
  parameter int unsigned DATASIZE = 8
);
  import regbank85_pkg::*;

  logic                    enb;
  logic [SEL_W-1:0]        sel;
  logic [DATASIZE-1:0]     data_in;
  logic [DATASIZE-1:0]     data_out;
  logic [PAIR_W-1:0]       psel;
  logic                    pinc;
  logic                    pdec;
  logic                    pload;
  logic [2*DATASIZE-1:0]   pdata_out;
  logic                    busy;
  logic                    done;

  modport master (
    output enb, sel, data_in, psel, pinc, pdec, pload,
    input  data_out, pdata_out, busy, done
  );

  modport slave (
    input  enb, sel, data_in, psel, pinc, pdec, pload,
    output data_out, pdata_out, busy, done
  );

endinterface

// File: rtl/regbank85_pair_incdec.sv
// regbank85_pair_incdec: combinational +1 / -1 / hold on a register pair.
//   i_val    pair value
//   i_inc    increment request
//   i_dec    decrement request (both together hold the value)
//   o_val_c  resulting value, wraps modulo 2^W
module regbank85_pair_incdec #(
  parameter int unsigned W = 16
) (
  input  logic [W-1:0] i_val,
  input  logic         i_inc,
  input  logic         i_dec,
  output logic [W-1:0] o_val_c
);

  always_comb begin
    o_val_c = i_val;
    if (i_inc && !i_dec) begin
      o_val_c = i_val + W'(1);
    end else if (i_dec && !i_inc) begin
      o_val_c = i_val - W'(1);
    end
  end

endmodule

// File: rtl/regbank85.sv
// regbank85: 8085 general register bank (A,B,C,D,E,H,L, SP).
//   clk   system clock, rising edge
//   rst   asynchronous active-low reset
//   bus   regbank85_if slave: byte write/read, pair inc/dec/read,
//         two-byte pair load sequencer with busy/done
module regbank85
  import regbank85_pkg::*;
#(
  parameter int unsigned DATASIZE = DATASIZE_DEF
) (
  input  logic        clk,
  input  logic        rst,
  regbank85_if.slave  bus
);

  localparam int unsigned PW = 2 * DATASIZE;

  // Storage: bytes indexed by select code (slot 6 unused), SP separate
  logic [DATASIZE-1:0] r_byte [NUM_BYTES];
  logic [PW-1:0]       r_sp;

  state_e              r_state;
  state_e              w_state_nxt;
  logic [PAIR_W-1:0]   r_lpair;
  logic [PAIR_W-1:0]   w_lpair_nxt;
  logic                r_done;
  logic                w_done_nxt;

  logic [PW-1:0]       w_pair_val [4];
  logic [PW-1:0]       w_lpair_val;
  logic [PW-1:0]       w_incdec;

  // Single pair write port and single byte write port per cycle
  logic                w_pwe;
  logic [PAIR_W-1:0]   w_pidx;
  logic [PW-1:0]       w_pwdata;
  logic                w_bwe;
  logic [SEL_W-1:0]    w_bidx;
  logic [DATASIZE-1:0] w_bwdata;
  logic                w_pair_hit;

  assign w_pair_val[0] = {r_byte[0], r_byte[1]};
  assign w_pair_val[1] = {r_byte[2], r_byte[3]};
  assign w_pair_val[2] = {r_byte[4], r_byte[5]};
  assign w_pair_val[3] = r_sp;
  assign w_lpair_val   = w_pair_val[r_lpair];

  regbank85_pair_incdec #(.W(PW)) u_incdec (
    .i_val   (w_pair_val[bus.psel]),
    .i_inc   (bus.pinc),
    .i_dec   (bus.pdec),
    .o_val_c (w_incdec)
  );

  // Byte write targets a byte of the pair being incremented/decremented
  assign w_pair_hit = (bus.psel != PAIR_SP) && (bus.sel[SEL_W-1:1] == bus.psel);

  assign bus.data_out  = (bus.sel == REG_NONE) ? '0 : r_byte[bus.sel];
  assign bus.pdata_out = w_pair_val[bus.psel];
  assign bus.busy      = (r_state != ST_IDLE);
  assign bus.done      = r_done;

  // FSM state, latched load target and done pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_lpair <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_lpair <= w_lpair_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Next state and write-port control
  always_comb begin
    w_state_nxt = r_state;
    w_lpair_nxt = r_lpair;
    w_done_nxt  = 1'b0;
    w_pwe       = 1'b0;
    w_pidx      = bus.psel;
    w_pwdata    = w_incdec;
    w_bwe       = 1'b0;
    w_bidx      = bus.sel;
    w_bwdata    = bus.data_in;

    unique case (r_state)
      ST_IDLE: begin
        w_pwe = bus.pinc || bus.pdec;
        w_bwe = bus.enb && (bus.sel != REG_NONE) && !(w_pwe && w_pair_hit);
        if (bus.pload) begin
          w_state_nxt = ST_LOAD_LO;
          w_lpair_nxt = bus.psel;
        end
      end
      ST_LOAD_LO: begin
        if (bus.enb) begin
          w_pwe       = 1'b1;
          w_pidx      = r_lpair;
          w_pwdata    = {w_lpair_val[PW-1:DATASIZE], bus.data_in};
          w_state_nxt = ST_LOAD_HI;
        end
      end
      ST_LOAD_HI: begin
        if (bus.enb) begin
          w_pwe       = 1'b1;
          w_pidx      = r_lpair;
          w_pwdata    = {bus.data_in, w_lpair_val[DATASIZE-1:0]};
          w_state_nxt = ST_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Register storage; the two write ports never target the same byte
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(NUM_BYTES); i++) begin
        r_byte[i] <= '0;
      end
      r_sp <= '0;
    end else begin
      if (w_pwe) begin
        case (w_pidx)
          PAIR_SP: r_sp <= w_pwdata;
          default: begin
            r_byte[{w_pidx, 1'b0}] <= w_pwdata[PW-1:DATASIZE];
            r_byte[{w_pidx, 1'b1}] <= w_pwdata[DATASIZE-1:0];
          end
        endcase
      end
      if (w_bwe) begin
        r_byte[w_bidx] <= w_bwdata;
      end
    end
  end

endmodule
